// File: rtl/fifo_umbrales_status.sv
// fifo_umbrales_status: sync FIFO with threshold-driven status (empty/full/error/pause/almost-empty).
// Define UMBRAL_CHECK_EN to reject illegal threshold pairs and raise a sticky cfg_error.
module fifo_umbrales_status #(
    parameter int DATA_WIDTH      = 6,
    parameter int ADDR_WIDTH      = 3,
    parameter int UMBRAL_HIGH_DEF = 6,
    parameter int UMBRAL_LOW_DEF  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_high,
    input  logic [ADDR_WIDTH:0]   umbral_low,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  pause,
    output logic                  almost_empty,
    output logic                  fifo_error,
    output logic                  cfg_error
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL = CW'(2 ** ADDR_WIDTH);

    typedef enum logic {NORMAL, PAUSED} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] mem [2 ** ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
    logic [ADDR_WIDTH:0]   high_q, low_q, high_n, low_n, cnt_n;
    logic                  pop_ok, push_ok, cfg_ok, err_n;

    always_comb begin
        pop_ok  = pop && count != '0;
        // a full FIFO still takes a write when a read frees a slot in the same cycle
        push_ok = push && (count != FULL || pop_ok);
        err_n   = (push && !push_ok) || (pop && !pop_ok);
        cnt_n   = count + CW'(push_ok) - CW'(pop_ok);
`ifdef UMBRAL_CHECK_EN
        cfg_ok  = init && umbral_low < umbral_high && umbral_high <= FULL;
`else
        cfg_ok  = init;
`endif
        high_n  = cfg_ok ? umbral_high : high_q;
        low_n   = cfg_ok ? umbral_low : low_q;
    end

    always_ff @(posedge clk)
        if (!reset && push_ok) mem[wr_ptr] <= data_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            fifo_empty   <= 1'b1;
            fifo_full    <= 1'b0;
            almost_empty <= 1'b1;
            fifo_error   <= 1'b0;
            high_q       <= CW'(UMBRAL_HIGH_DEF);
            low_q        <= CW'(UMBRAL_LOW_DEF);
            state        <= NORMAL;
            pause        <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                data_out <= mem[rd_ptr];
            end
            valid_out    <= pop_ok;
            count        <= cnt_n;
            fifo_empty   <= cnt_n == '0;
            fifo_full    <= cnt_n == FULL;
            almost_empty <= cnt_n <= low_n;
            fifo_error   <= fifo_error | err_n;
            high_q       <= high_n;
            low_q        <= low_n;
            // release takes priority in PAUSED, entry takes priority in NORMAL
            if (state == PAUSED) begin
                if (cnt_n <= low_n) begin
                    state <= NORMAL;
                    pause <= 1'b0;
                end
            end else if (cnt_n >= high_n) begin
                state <= PAUSED;
                pause <= 1'b1;
            end
        end
    end

`ifdef UMBRAL_CHECK_EN
    always_ff @(posedge clk)
        if (reset) cfg_error <= 1'b0;
        else if (init && !cfg_ok) cfg_error <= 1'b1;
`else
    assign cfg_error = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_umbrales_status.sv
// tb_fifo_umbrales_status: scoreboard bench; reference queue model predicts count/flags, popped words checked on valid_out.
module tb_fifo_umbrales_status;
    logic       clk = 1'b0;
    logic       reset, init, push, pop;
    logic [3:0] umbral_high, umbral_low;
    logic [5:0] data_in;
    logic [5:0] data_out;
    logic       valid_out, fifo_empty, fifo_full, pause, almost_empty, fifo_error, cfg_error;
    logic [3:0] count;

    fifo_umbrales_status dut (
        .clk(clk), .reset(reset), .init(init), .umbral_high(umbral_high), .umbral_low(umbral_low),
        .push(push), .data_in(data_in), .pop(pop), .data_out(data_out), .valid_out(valid_out),
        .count(count), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .pause(pause),
        .almost_empty(almost_empty), .fifo_error(fifo_error), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int mq[$], exp_q[$];
    int hi, lo;
    bit ps, err, cerr, ev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rs, input bit pu, input int d, input bit po,
                        input bit in = 0, input int h = 0, input int l = 0);
        bit pop_ok, push_ok;
        int cn;
        reset = rs; push = pu; data_in = 6'(d); pop = po; init = in;
        umbral_high = 4'(h); umbral_low = 4'(l);
        if (rs) begin
            mq.delete(); exp_q.delete();
            hi = 6; lo = 2; ps = 0; err = 0; cerr = 0; ev = 0;
        end else begin
            pop_ok  = po && mq.size() != 0;
            push_ok = pu && (mq.size() != 8 || pop_ok);
            if (pop_ok) exp_q.push_back(mq.pop_front());
            if (push_ok) mq.push_back(d & 6'h3f);
            if ((pu && !push_ok) || (po && !pop_ok)) err = 1;
            ev = pop_ok;
            if (in) begin
`ifdef UMBRAL_CHECK_EN
                if ((l & 15) < (h & 15) && (h & 15) <= 8) begin hi = h & 15; lo = l & 15; end
                else cerr = 1;
`else
                hi = h & 15; lo = l & 15;
`endif
            end
            cn = mq.size();
            ps = ps ? !(cn <= lo) : (cn >= hi);
        end
        @(posedge clk);
        #1;
        cn = mq.size();
        chk("valid_out", valid_out, ev);
        if (valid_out && exp_q.size() != 0) chk("data_out", data_out, exp_q.pop_front());
        chk("count", count, cn);
        chk("fifo_empty", fifo_empty, cn == 0);
        chk("fifo_full", fifo_full, cn == 8);
        chk("almost_empty", almost_empty, cn <= lo);
        chk("pause", pause, ps);
        chk("fifo_error", fifo_error, err);
        chk("cfg_error", cfg_error, cerr);
        reset = 0; init = 0; push = 0; pop = 0;
    endtask

    initial begin
        reset = 1; init = 0; push = 0; pop = 0; data_in = 0; umbral_high = 0; umbral_low = 0;
        step(1, 0, 0, 0);
        step(1, 1, 7, 1, 1, 3, 1);
        step(0, 0, 0, 0);
        // thresholds 5/1, pause at 5, release at 1
        step(0, 0, 0, 0, 1, 5, 1);
        for (int i = 1; i <= 5; i++) step(0, 1, i, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // full with pass-through traffic wrapping the pointers
        for (int i = 0; i < 8; i++) step(0, 1, 8'h10 + i, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 8'h20 + i, 1);
        // overflow, then error stays through legal traffic
        step(0, 1, 6'h3f, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
        step(0, 1, 5, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        // underflow with a simultaneous push
        step(0, 1, 6'h2a, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        // illegal pairs: low>=high, high>DEPTH
        step(0, 0, 0, 0, 1, 2, 4);
        for (int i = 0; i < 4; i++) step(0, 1, i, 0);
        step(0, 0, 0, 0, 1, 9, 3);
        for (int i = 0; i < 5; i++) step(0, 1, i + 9, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            step(i % 97 == 96, $urandom_range(0, 3) != 0, $urandom_range(0, 63), $urandom_range(0, 2) == 0 || i > 150 && $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 10), $urandom_range(0, 8));
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
